// File: rtl/phase_reconstruct.sv
// Back end of the atan2 datapath: re-pairs buffered octant flags with arctangent
// results in arrival order and unfolds them to a full-circle binary angle.
module phase_reconstruct #(
  parameter int FIFO_DEPTH = 8,
  parameter int ATAN_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_val_i,
  input  logic [2:0]        case_flag_i,
  output logic              flag_ready_o,
  input  logic              atan_val_i,
  input  logic [ATAN_W-1:0] atan_i,
  output logic [ATAN_W+2:0] phase_o,
  output logic              val_o,
  output logic [1:0]        err_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int PH_W  = ATAN_W + 3;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PH_W-1:0]  UNIT     = PH_W'(1) << ATAN_W;

  logic [2:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              r_s1_val;
  logic [2:0]        r_s1_flag;
  logic [ATAN_W-1:0] r_s1_atan;

  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_overflow;
  logic              w_underflow;
  logic [PH_W-1:0]   w_base;
  logic [PH_W-1:0]   w_a_ext;
  logic [PH_W-1:0]   w_phase;

  // Ready comes from the registered count only, so a pop never frees a slot
  // for a push in the same cycle.
  assign flag_ready_o = (r_count != FULL_CNT);
  assign w_empty      = (r_count == '0);

  assign w_push      = !rst && flag_val_i && flag_ready_o;
  assign w_pop       = !rst && atan_val_i && !w_empty;
  assign w_overflow  = flag_val_i && !flag_ready_o;
  assign w_underflow = atan_val_i && w_empty;

  // NOTE: storage array has no reset; pointers and count define what is valid,
  // so clearing the entries would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= case_flag_i;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Stage 1: popped flag paired with its arctangent sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_val  <= 1'b0;
      r_s1_flag <= '0;
      r_s1_atan <= '0;
    end else begin
      r_s1_val <= w_pop;
      if (w_pop) begin
        r_s1_flag <= r_mem[r_rd_ptr];
        r_s1_atan <= atan_i;
      end
    end
  end

  // Odd octants run backwards from the next octant boundary; the modulo-2^PH_W
  // adder wraps k=7, a=0 to zero.
  assign w_base  = {r_s1_flag, {ATAN_W{1'b0}}};
  assign w_a_ext = PH_W'(r_s1_atan);
  assign w_phase = r_s1_flag[0] ? (w_base + UNIT - w_a_ext)
                                : (w_base + w_a_ext);

  // Stage 2: registered result, held between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_o <= '0;
      val_o   <= 1'b0;
    end else begin
      val_o <= r_s1_val;
      if (r_s1_val) begin
        phase_o <= w_phase;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= '0;
    end else begin
      err_o <= err_o | {w_overflow, w_underflow};
    end
  end

endmodule

// File: tb/tb_phase_reconstruct.sv
// Self-checking bench for phase_reconstruct: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_phase_reconstruct;

  localparam int DEPTH  = 8;
  localparam int ATAN_W = 8;
  localparam int PH_W   = ATAN_W + 3;

  logic              clk;
  logic              rst;
  logic              flag_val_i;
  logic [2:0]        case_flag_i;
  logic              flag_ready_o;
  logic              atan_val_i;
  logic [ATAN_W-1:0] atan_i;
  logic [PH_W-1:0]   phase_o;
  logic              val_o;
  logic [1:0]        err_o;

  phase_reconstruct #(.FIFO_DEPTH(DEPTH), .ATAN_W(ATAN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flag_val_i   (flag_val_i),
    .case_flag_i  (case_flag_i),
    .flag_ready_o (flag_ready_o),
    .atan_val_i   (atan_val_i),
    .atan_i       (atan_i),
    .phase_o      (phase_o),
    .val_o        (val_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  int     m_q[$];
  bit     m_p1_v;
  int     m_p1_ph;
  bit     m_v;
  int     m_ph;
  bit [1:0] m_err;

  typedef struct {
    int k;
    int a;
    int exp_phase;
  } vec_t;

  vec_t tbl[11];

  function automatic int unfold(input int k, input int a);
    int p;
    if (k % 2 == 0) p = k * (1 << ATAN_W) + a;
    else            p = (k + 1) * (1 << ATAN_W) - a;
    return p % (1 << PH_W);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare outputs.
  task automatic cycle(input bit r, input bit fv, input int k, input bit av, input int a);
    bit rdy;
    rst         = r;
    flag_val_i  = fv;
    case_flag_i = 3'(k);
    atan_val_i  = av;
    atan_i      = ATAN_W'(a);
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_p1_v = 1'b0;
      m_v    = 1'b0;
      m_ph   = 0;
      m_err  = 2'b00;
    end else begin
      rdy = (m_q.size() != DEPTH);
      m_v = m_p1_v;
      if (m_p1_v) m_ph = m_p1_ph;
      m_p1_v = 1'b0;
      if (av) begin
        if (m_q.size() == 0) begin
          m_err[0] = 1'b1;
        end else begin
          m_p1_v  = 1'b1;
          m_p1_ph = unfold(m_q.pop_front(), a);
        end
      end
      if (fv) begin
        if (rdy) m_q.push_back(k);
        else     m_err[1] = 1'b1;
      end
    end
    #1;
    check("val",   val_o, m_v);
    check("phase", phase_o, m_ph);
    check("ready", flag_ready_o, m_q.size() != DEPTH);
    check("err",   err_o, m_err);
    rst        = 1'b0;
    flag_val_i = 1'b0;
    atan_val_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  int ord_a[4]   = '{100, 100, 10, 255};
  int ord_exp[4] = '{100, 412, 1014, 1791};

  initial begin
    tbl[0]  = '{0, 100, 100};
    tbl[1]  = '{1, 100, 412};
    tbl[2]  = '{3, 10, 1014};
    tbl[3]  = '{6, 255, 1791};
    tbl[4]  = '{7, 0, 0};
    tbl[5]  = '{7, 1, 2047};
    tbl[6]  = '{0, 0, 0};
    tbl[7]  = '{2, 5, 517};
    tbl[8]  = '{4, 20, 1044};
    tbl[9]  = '{5, 0, 1536};
    tbl[10] = '{1, 255, 257};

    rst = 1'b1; flag_val_i = 1'b0; case_flag_i = '0; atan_val_i = 1'b0; atan_i = '0;

    // Reset state
    cycle(1, 1, 3, 1, 7);
    check("rst_phase", phase_o, 0);
    check("rst_val", val_o, 0);
    check("rst_err", err_o, 0);
    check("rst_ready", flag_ready_o, 1);

    // Vector table: push, pop, result two cycles after the pop
    for (int i = 0; i < 11; i++) begin
      cycle(0, 1, tbl[i].k, 0, 0);
      cycle(0, 0, 0, 1, tbl[i].a);
      cycle(0, 0, 0, 0, 0);
      check("tbl_val", val_o, 1);
      check("tbl_phase", phase_o, tbl[i].exp_phase);
      cycle(0, 0, 0, 0, 0);
      check("tbl_hold", phase_o, tbl[i].exp_phase);
    end

    // Back-to-back octant unfold
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 3, 0, 0);
    cycle(0, 1, 6, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, i < 4, ord_a[i % 4]);
      if (i >= 1 && i <= 4) begin
        check("seq_val", val_o, 1);
        check("seq_phase", phase_o, ord_exp[i - 1]);
      end else begin
        check("seq_idle", val_o, 0);
      end
    end
    check("seq_err", err_o, 0);

    // Fill, overflow, drain in order
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 1, i, 0, 0);
      check("fill_ready", flag_ready_o, i != DEPTH - 1);
    end
    cycle(0, 1, 3, 0, 0);
    check("ovf_err", err_o, 2'b10);
    for (int i = 0; i < DEPTH + 2; i++) begin
      cycle(0, 0, 0, i < DEPTH, i * 3);
      if (i == 0) check("ready_rise", flag_ready_o, 1);
      if (i >= 1 && i <= DEPTH) check("drain_phase", phase_o, unfold(i - 1, (i - 1) * 3));
    end

    // Simultaneous push and pop while full: pop wins, push refused
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 7 - i, 0, 0);
    cycle(0, 1, 6, 1, 9);
    check("full_pp_err", err_o, 2'b10);
    cycle(0, 0, 0, 0, 0);
    check("full_pp_phase", phase_o, unfold(7, 9));
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 1, 40 + i);
    check("full_pp_unf", err_o, 2'b11);
    idle(2);

    // Underflow
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 50);
    check("unf_err", err_o, 2'b01);
    idle(2);
    check("unf_noval", val_o, 0);
    cycle(0, 1, 2, 0, 0);
    cycle(0, 0, 0, 1, 5);
    cycle(0, 0, 0, 0, 0);
    check("unf_phase", phase_o, 517);
    check("unf_sticky", err_o, 2'b01);

    // Simultaneous push and pop at count 1 for 20 cycles
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 5, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, $urandom_range(7), 1, $urandom_range(255));
    cycle(0, 0, 0, 1, 33);
    idle(2);
    check("pp1_err", err_o, 0);

    // Reset mid-stream with flags queued and samples in flight
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, i, 0, 0);
    cycle(0, 0, 0, 1, 11);
    cycle(0, 0, 0, 1, 12);
    cycle(0, 1, 1, 0, 0);
    cycle(1, 1, 2, 1, 13);
    check("mid_rst_ready", flag_ready_o, 1);
    check("mid_rst_err", err_o, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      check("mid_rst_noval", val_o, 0);
    end
    cycle(0, 1, 4, 0, 0);
    cycle(0, 0, 0, 1, 20);
    cycle(0, 0, 0, 0, 0);
    check("mid_rst_phase", phase_o, 1044);
    check("mid_rst_err2", err_o, 0);

    // Randomized traffic: push-heavy then pop-heavy, with rare resets
    for (int i = 0; i < 600; i++) begin
      bit r;
      bit fv;
      bit av;
      r  = ($urandom_range(149) == 0);
      if (i < 300) begin
        fv = ($urandom_range(3) != 0);
        av = ($urandom_range(3) == 0);
      end else begin
        fv = ($urandom_range(3) == 0);
        av = ($urandom_range(3) != 0);
      end
      cycle(r, fv, $urandom_range(7), av, $urandom_range((1 << ATAN_W) - 1));
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
